// File: rtl/ariane_pkg.sv
// Shared CFI log record type and queue sizing constants for the CFI logging path.
package ariane_pkg;

  localparam int unsigned VLEN          = 64;
  localparam int unsigned CFI_LOG_DEPTH = 8;
  localparam int unsigned DROP_CNT_W    = 16;

  typedef struct packed {
    logic [31:0]     instr;
    logic [VLEN-1:0] addr_pc;
    logic [VLEN-1:0] addr_npc;
    logic [VLEN-1:0] addr_target;
  } cfi_log_t;

endpackage

// File: rtl/cfi_log_queue.sv
// Multi-port CFI log queue: compacts per-port pushes into a circular buffer, drops
// (and counts) logs that do not fit, and presents the head entry to one consumer.
module cfi_log_queue
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = CFI_LOG_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  cfi_log_t                   log_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] log_valid_i,
  output cfi_log_t                   log_o,
  output logic                       log_valid_o,
  input  logic                       log_ready_i,
  output logic                       stall_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  input  logic                       clear_i
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned DW1 = DROP_CNT_W + 1;

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         free, n_valid, n_push, n_drop, slot_sum;
  logic [NR_COMMIT_PORTS-1:0] accept;
  logic [PW-1:0]         slot [NR_COMMIT_PORTS];
  logic                  pop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d, drop_base;
  logic [DW1-1:0]        drop_sum;
  logic                  overflow_q, overflow_d;
  cfi_log_t              mem_q [DEPTH];

  // Free space comes from the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    n_valid  = '0;
    slot_sum = '0;
    accept   = '0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      accept[i] = log_valid_i[i] && (n_valid < free);
      slot_sum  = {1'b0, wr_ptr_q} + n_valid;
      slot[i]   = slot_sum[PW-1:0];
      if (log_valid_i[i]) n_valid = n_valid + CW'(1);
    end
    n_push   = (n_valid < free) ? n_valid : free;
    n_drop   = n_valid - n_push;
    pop      = (count_q != '0) && log_ready_i;
    count_d  = count_q + n_push - CW'(pop);
    wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
    rd_ptr_d = rd_ptr_q + PW'(pop);

    // Clear takes effect before this cycle's drops are added.
    drop_base  = clear_i ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, drop_base} + DW1'(n_drop);
    drop_cnt_d = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_W-1:0];
    overflow_d = (overflow_q && !clear_i) || (n_drop != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (accept[i]) mem_q[slot[i]] <= log_i[i];
    end
  end

  assign log_valid_o = (count_q != '0);
  assign log_o       = mem_q[rd_ptr_q];
  assign stall_o     = free < CW'(NR_COMMIT_PORTS);
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_cfi_log_queue.sv
// Bench for cfi_log_queue: reference queue model with scoreboard, a vector table for
// fill/drop/clear behaviour, and hand sequences for saturation and mid-stream reset.
module tb_cfi_log_queue;
  import ariane_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;
  localparam int LW    = $bits(cfi_log_t);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  cfi_log_t       log_i [NR];
  logic [NR-1:0]  log_valid_i = '0;
  cfi_log_t       log_o;
  logic           log_valid_o;
  logic           log_ready_i = 1'b0;
  logic           stall_o;
  logic           overflow_o;
  logic [15:0]    drop_cnt_o;
  logic           clear_i = 1'b0;

  cfi_log_queue #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .log_i(log_i), .log_valid_i(log_valid_i),
    .log_o(log_o), .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .stall_o(stall_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] exp_q[$];
  int            mdl_drop = 0;
  logic          mdl_ovf  = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  logic          use_fixed = 1'b0;
  logic [31:0]   fixed_instr = '0;

  typedef struct {
    logic [1:0]  v;
    logic        r;
    logic        c;
    logic        e_valid;
    logic        e_stall;
    logic        e_ovf;
    logic [15:0] e_drop;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cfi_log_t make_log();
    cfi_log_t l;
    l.instr       = use_fixed ? fixed_instr : $urandom;
    l.addr_pc     = {$urandom, $urandom};
    l.addr_npc    = {$urandom, $urandom};
    l.addr_target = {$urandom, $urandom};
    return l;
  endfunction

  // Called at a negedge; checks pre-edge outputs, advances the model, returns at the next negedge.
  task automatic cycle(input logic [NR-1:0] v, input logic r, input logic c);
    int free;
    int ndrop;
    log_valid_i = v;
    log_ready_i = r;
    clear_i     = c;
    for (int p = 0; p < NR; p++) log_i[p] = make_log();
    #1;
    check("log_valid_o", log_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) check("log_o", log_o, exp_q[0]);
    check("stall_o", stall_o, (DEPTH - exp_q.size()) < NR);
    check("overflow_o", overflow_o, mdl_ovf);
    check("drop_cnt_o", drop_cnt_o, mdl_drop[15:0]);
    free  = DEPTH - exp_q.size();
    ndrop = 0;
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    for (int p = 0; p < NR; p++) begin
      if (v[p]) begin
        if (free > 0) begin
          exp_q.push_back(log_i[p]);
          free--;
        end else begin
          ndrop++;
        end
      end
    end
    mdl_drop = (c ? 0 : mdl_drop) + ndrop;
    if (mdl_drop > 65535) mdl_drop = 65535;
    mdl_ovf = (c ? 1'b0 : mdl_ovf) | (ndrop != 0);
    @(posedge clk);
    @(negedge clk);
    log_valid_i = '0;
    log_ready_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < NR; p++) log_i[p] = '0;
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3};
    tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd5};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    for (int k = 10; k < 15; k++) tbl[k] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[15] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    // Clock/reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", log_valid_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    check("rst_drop", drop_cnt_o, 16'd0);

    // Single push into an empty queue shows up one cycle later, then drains.
    use_fixed   = 1'b1;
    fixed_instr = 32'h0000006F;
    cycle(2'b01, 1'b0, 1'b0);
    use_fixed = 1'b0;
    check("first_valid", log_valid_o, 1'b1);
    check("first_instr", log_o.instr, 32'h0000006F);
    cycle(2'b00, 1'b1, 1'b0);
    check("first_empty", log_valid_o, 1'b0);

    // Vector table: fill, overflow, pop-with-push, clear, drain.
    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].v, tbl[k].r, tbl[k].c);
      check($sformatf("tbl%0d_valid", k), log_valid_o, tbl[k].e_valid);
      check($sformatf("tbl%0d_stall", k), stall_o, tbl[k].e_stall);
      check($sformatf("tbl%0d_ovf", k), overflow_o, tbl[k].e_ovf);
      check($sformatf("tbl%0d_drop", k), drop_cnt_o, tbl[k].e_drop);
    end

    // Saturate the drop counter, then clear without and with a simultaneous drop.
    repeat (4) cycle(2'b11, 1'b0, 1'b0);
    repeat (32768) cycle(2'b11, 1'b0, 1'b0);
    check("sat_drop", drop_cnt_o, 16'hFFFF);
    cycle(2'b11, 1'b0, 1'b0);
    check("sat_hold", drop_cnt_o, 16'hFFFF);
    cycle(2'b00, 1'b0, 1'b1);
    check("clr_drop", drop_cnt_o, 16'd0);
    check("clr_ovf", overflow_o, 1'b0);
    cycle(2'b11, 1'b0, 1'b1);
    check("clrdrop_drop", drop_cnt_o, 16'd2);
    check("clrdrop_ovf", overflow_o, 1'b1);

    // Asynchronous reset with five entries queued.
    repeat (3) cycle(2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("async_valid", log_valid_o, 1'b0);
    check("async_drop", drop_cnt_o, 16'd0);
    check("async_ovf", overflow_o, 1'b0);
    check("async_stall", stall_o, 1'b0);
    exp_q.delete();
    mdl_drop = 0;
    mdl_ovf  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(2'b10, 1'b0, 1'b0);
    check("post_rst_valid", log_valid_o, 1'b1);

    // Random traffic against the model.
    repeat (400) begin
      cycle(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cfi_log_queue.md
CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of CFI log producer ports.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries; power of two, at least NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port log_i, input, cfi_log_t[NR_COMMIT_PORTS], per-port CFI commit logs from the filter.
REQ-006 SHALL have port log_valid_i, input, [NR_COMMIT_PORTS], per-port push strobes.
REQ-007 SHALL have port log_o, output, cfi_log_t, head entry to the consumer.
REQ-008 SHALL have port log_valid_o, output, 1, head entry valid.
REQ-009 SHALL have port log_ready_i, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port stall_o, output, 1, free entries < NR_COMMIT_PORTS; back-pressure to commit.
REQ-011 SHALL have port overflow_o, output, 1, sticky: at least one log dropped since reset or clear.
REQ-012 SHALL have port drop_cnt_o, output, 16, saturating count of dropped logs.
REQ-013 SHALL have port clear_i, input, 1, synchronous clear of overflow_o and drop_cnt_o.

Function
REQ-014 SHALL keep circular storage with read pointer, write pointer and occupancy count of $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-015 SHALL accept, in one cycle, up to F = DEPTH - count valid logs, with F taken from the registered count before any same-cycle pop.
REQ-016 SHALL write accepted logs in ascending port index order, lowest-index valid port into the write-pointer slot; invalid ports consume no slot.
REQ-017 SHALL drop valid logs beyond F, choosing the highest-index ones, and add the number dropped to drop_cnt_o, saturating at 16'hFFFF.
REQ-018 SHALL set overflow_o the cycle after any drop; it stays set until clear_i or reset.
REQ-019 SHALL, when clear_i and a drop happen in the same cycle, clear first, then count the new drops (drop_cnt_o = drops, overflow_o = 1).
REQ-020 SHALL drive log_valid_o = (count != 0) and log_o = storage[read pointer], both from registered state only.
REQ-021 SHALL pop the head when log_valid_o && log_ready_i; log_ready_i with an empty queue SHALL have no effect.
REQ-022 SHALL update count as count + pushes - pop when push and pop happen together; a full queue with a pop accepts no push that cycle (per REQ-015).
REQ-023 SHALL present a log pushed in cycle N on log_o no earlier than cycle N+1; pushed into an empty queue, exactly N+1.
REQ-024 SHALL drive stall_o combinationally from the registered count: stall_o = (DEPTH - count) < NR_COMMIT_PORTS.
REQ-025 SHALL hold log_o stable while log_valid_o && !log_ready_i.

Reset
REQ-026 SHALL, on rst_i asserted, clear pointers and count at once, without a clock; outputs then read log_valid_o=0, stall_o=0, overflow_o=0, drop_cnt_o=0.
REQ-027 SHALL not reset the storage array; log_o is don't-care while log_valid_o=0.
REQ-028 SHALL discard all queued entries on reset mid-operation; after release, the first push appears on log_o one cycle later.

Structure
REQ-029 SHALL take cfi_log_t from ariane_pkg (instr 32b; addr_pc, addr_npc, addr_target VLEN each) and place CFI_LOG_DEPTH default and DROP_CNT_W=16 there.
REQ-030 SHALL be a single module with no sub-modules; the multi-port push compaction is an in-module prefix count over log_valid_i.

Verification
REQ-031 Empty queue, port0 valid instr=32'h0000006F in cycle 0 -> log_valid_o=1 in cycle 1 with instr 32'h6F; ready=1 -> empty in cycle 2.
REQ-032 Both ports valid (A on port0, B on port1), ready=0 for 4 cycles -> count=8, stall_o=1 from count 7; log_o order A,B,A,B...
REQ-033 Full queue, both valid, ready=0 -> drop_cnt_o=2, overflow_o=1 next cycle; queue contents unchanged.
REQ-034 Count=7, port0 and port1 valid, ready=1 same cycle -> port0 stored, port1 dropped, count stays 7, drop_cnt_o +1.
REQ-035 drop_cnt_o=16'hFFFF, another drop -> stays 16'hFFFF; clear_i=1 with no drop -> 0, overflow_o=0.
REQ-036 rst_i asserted mid-stream with count=5 -> log_valid_o=0 immediately, before the next clock edge; all counters 0.
